unidade_controle: RTL and testbench

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

---
 rtl/polilobinho_pkg.sv | 27 ++
 rtl/unidade_controle.sv | 164 ++++++++++++++++
 tb/tb_unidade_controle.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/polilobinho_pkg.sv
// Shared definitions for the polilobinho game: control FSM state codes and
// the default auto-advance timeout.
package polilobinho_pkg;

   localparam int unsigned ESTADO_W              = 4;
   localparam int unsigned TIMEOUT_CICLOS_PADRAO = 1000;

   typedef enum logic [ESTADO_W-1:0] {
      INICIAL        = 4'd0,
      PREPARA        = 4'd1,
      CARREGA        = 4'd2,
      NOITE_MOSTRA   = 4'd3,
      NOITE_ACAO     = 4'd4,
      NOITE_PROX     = 4'd5,
      NOITE_ESPERA   = 4'd6,
      AVALIA         = 4'd7,
      VERIFICA_NOITE = 4'd8,
      DIA_VOTO       = 4'd9,
      DIA_VOTA       = 4'd10,
      DIA_CHECA      = 4'd11,
      DIA_ELIMINA    = 4'd12,
      VERIFICA_DIA   = 4'd13,
      FIM_LOBO       = 4'd14,
      FIM_ALDEIA     = 4'd15
   } estado_t;

endpackage

// File: rtl/unidade_controle.sv
// Game control unit: Moore FSM sequencing setup, night actions, day vote
// and end-of-game for the polilobinho datapath.
//
// Ports:
//   clock, rst_global_n          clock, synchronous active-low reset
//   iniciar, confirma            button pulses
//   CJ_fim, jogador_vivo, votou,
//   acertou, sinal_lobo_ganhou   datapath status
//   rst_global ... morra         datapath controls (active-high)
//   lobo_venceu, aldeia_venceu   end-of-game flags
//   db_estado                    current state code
//
// Optional feature: define CONTROLE_TIMEOUT_EN to auto-advance NOITE_MOSTRA
// and DIA_VOTO after TIMEOUT_CICLOS idle cycles.
module unidade_controle
   import polilobinho_pkg::*;
#(
   parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
   input  logic                clock,
   input  logic                rst_global_n,
   input  logic                iniciar,
   input  logic                confirma,
   input  logic                CJ_fim,
   input  logic                jogador_vivo,
   input  logic                votou,
   input  logic                acertou,
   input  logic                sinal_lobo_ganhou,
   output logic                rst_global,
   output logic                zera_CS,
   output logic                zera_CJ,
   output logic                inc_seed,
   output logic                e_seed_reg,
   output logic                inc_jogador,
   output logic                mostra_classe,
   output logic                processar_acao,
   output logic                avaliar_eliminacao,
   output logic                voto,
   output logic                morra,
   output logic                lobo_venceu,
   output logic                aldeia_venceu,
   output logic [ESTADO_W-1:0] db_estado
);

   estado_t estado, prox;
   logic    expirou;

   // State register
   always_ff @(posedge clock) begin
      if (!rst_global_n) estado <= INICIAL;
      else               estado <= prox;
   end

`ifdef CONTROLE_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
   logic [CNT_W-1:0] cnt;

   // Counts cycles spent in a waiting state; any state change clears it
   always_ff @(posedge clock) begin
      if (!rst_global_n)
         cnt <= '0;
      else if ((estado == NOITE_MOSTRA || estado == DIA_VOTO) && prox == estado)
         cnt <= cnt + CNT_W'(1);
      else
         cnt <= '0;
   end

   assign expirou = (cnt == CNT_W'(TIMEOUT_CICLOS - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CICLOS;
   assign expirou        = 1'b0;
`endif

   // Seed counter clear follows the external reset only, never PREPARA
   assign zera_CS   = !rst_global_n;
   assign db_estado = estado;

   // Next state and state-decoded controls
   always_comb begin
      prox               = estado;
      rst_global         = 1'b0;
      zera_CJ            = 1'b0;
      inc_seed           = 1'b0;
      e_seed_reg         = 1'b0;
      inc_jogador        = 1'b0;
      mostra_classe      = 1'b0;
      processar_acao     = 1'b0;
      avaliar_eliminacao = 1'b0;
      voto               = 1'b0;
      morra              = 1'b0;
      lobo_venceu        = 1'b0;
      aldeia_venceu      = 1'b0;

      case (estado)
         INICIAL, FIM_LOBO, FIM_ALDEIA: begin
            inc_seed      = 1'b1;
            lobo_venceu   = (estado == FIM_LOBO);
            aldeia_venceu = (estado == FIM_ALDEIA);
            if (iniciar) prox = PREPARA;
         end
         PREPARA: begin
            rst_global = 1'b1;
            zera_CJ    = 1'b1;
            prox       = CARREGA;
         end
         CARREGA: begin
            e_seed_reg = 1'b1;
            prox       = NOITE_ESPERA;
         end
         NOITE_ESPERA: prox = NOITE_MOSTRA;
         NOITE_MOSTRA: begin
            mostra_classe = 1'b1;
            // Dead players and timeouts skip straight past the action
            if (!jogador_vivo || expirou) prox = NOITE_PROX;
            else if (confirma)            prox = NOITE_ACAO;
         end
         NOITE_ACAO: begin
            processar_acao = 1'b1;
            prox           = NOITE_PROX;
         end
         NOITE_PROX: begin
            if (CJ_fim) prox = AVALIA;
            else begin
               inc_jogador = 1'b1;
               prox        = NOITE_ESPERA;
            end
         end
         AVALIA: begin
            avaliar_eliminacao = 1'b1;
            zera_CJ            = 1'b1;
            prox               = VERIFICA_NOITE;
         end
         VERIFICA_NOITE: prox = sinal_lobo_ganhou ? FIM_LOBO : DIA_VOTO;
         DIA_VOTO: begin
            // Timeout counts as abstention: no elimination this day
            if (expirou)       prox = VERIFICA_DIA;
            else if (confirma) prox = DIA_VOTA;
         end
         DIA_VOTA: begin
            voto = 1'b1;
            prox = DIA_CHECA;
         end
         DIA_CHECA: begin
            if (!votou)       prox = DIA_VOTO;
            else if (acertou) prox = FIM_ALDEIA;
            else              prox = DIA_ELIMINA;
         end
         DIA_ELIMINA: begin
            morra = 1'b1;
            prox  = VERIFICA_DIA;
         end
         VERIFICA_DIA: begin
            if (sinal_lobo_ganhou) prox = FIM_LOBO;
            else begin
               zera_CJ = 1'b1;
               prox    = NOITE_ESPERA;
            end
         end
         default: prox = INICIAL;
      endcase
   end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed self-checking bench for unidade_controle.
module tb_unidade_controle;

   logic       clock = 1'b0;
   logic       rst_global_n, iniciar, confirma;
   logic       CJ_fim, jogador_vivo, votou, acertou, sinal_lobo_ganhou;
   logic       rst_global, zera_CS, zera_CJ, inc_seed, e_seed_reg, inc_jogador;
   logic       mostra_classe, processar_acao, avaliar_eliminacao, voto, morra;
   logic       lobo_venceu, aldeia_venceu;
   logic [3:0] db_estado;

   int n_assert = 0;
   int n_falhas = 0;
   int n_proc = 0, n_inc = 0, n_aval = 0, n_morra = 0, n_multi = 0;

   always #5 clock = ~clock;

   unidade_controle #(.TIMEOUT_CICLOS(8)) dut (
      .clock(clock), .rst_global_n(rst_global_n), .iniciar(iniciar), .confirma(confirma),
      .CJ_fim(CJ_fim), .jogador_vivo(jogador_vivo), .votou(votou), .acertou(acertou),
      .sinal_lobo_ganhou(sinal_lobo_ganhou), .rst_global(rst_global), .zera_CS(zera_CS),
      .zera_CJ(zera_CJ), .inc_seed(inc_seed), .e_seed_reg(e_seed_reg),
      .inc_jogador(inc_jogador), .mostra_classe(mostra_classe),
      .processar_acao(processar_acao), .avaliar_eliminacao(avaliar_eliminacao),
      .voto(voto), .morra(morra), .lobo_venceu(lobo_venceu),
      .aldeia_venceu(aldeia_venceu), .db_estado(db_estado)
   );

   // Pulse counters and exclusivity monitor, sampled mid-cycle
   always @(negedge clock) begin
      if (processar_acao)     n_proc++;
      if (inc_jogador)        n_inc++;
      if (avaliar_eliminacao) n_aval++;
      if (morra)              n_morra++;
      if (32'(processar_acao) + 32'(avaliar_eliminacao) + 32'(voto) + 32'(morra) > 1) n_multi++;
   end

   task automatic checa(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_falhas++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic ciclo();
      @(posedge clock);
      #1;
   endtask

   // One night; vivos[p]=1 means player p is alive. Ends sampling DIA_VOTO.
   task automatic noite(input logic [4:0] vivos);
      int p0, i0;
      p0 = n_proc; i0 = n_inc;
      for (int p = 0; p < 5; p++) begin
         checa("noite_mostra", 32'(db_estado), 3);
         checa("mostra_classe", 32'(mostra_classe), 1);
         jogador_vivo = vivos[p];
         if (vivos[p]) begin
            ciclo();
            checa("espera_confirma", 32'(db_estado), 3);
            confirma = 1'b1;
            ciclo();
            confirma = 1'b0;
            checa("noite_acao", 32'(db_estado), 4);
            checa("processar_acao", 32'(processar_acao), 1);
         end
         ciclo();
         checa("noite_prox", 32'(db_estado), 5);
         CJ_fim = (p == 4);
         #1;
         checa("inc_jogador", 32'(inc_jogador), (p == 4) ? 0 : 1);
         ciclo();
         CJ_fim = 1'b0;
         if (p < 4) begin
            checa("noite_espera", 32'(db_estado), 6);
            ciclo();
         end
      end
      checa("avalia", 32'(db_estado), 7);
      checa("avalia_sinais", 32'({avaliar_eliminacao, zera_CJ}), 3);
      ciclo();
      checa("verifica_noite", 32'(db_estado), 8);
      ciclo();
      checa("dia_voto", 32'(db_estado), 9);
      checa("noite_proc_pulsos", 32'(n_proc - p0), 32'($countones(vivos)));
      checa("noite_inc_pulsos", 32'(n_inc - i0), 4);
      jogador_vivo = 1'b1;
   endtask

   // From INICIAL/FIM_*: iniciar and walk setup into NOITE_MOSTRA
   task automatic inicia_jogo();
      iniciar = 1'b1;
      confirma = 1'b1;
      ciclo();
      iniciar = 1'b0;
      confirma = 1'b0;
      checa("prepara", 32'(db_estado), 1);
      checa("prepara_sinais", 32'({rst_global, zera_CJ, e_seed_reg, zera_CS}), 4'b1100);
      ciclo();
      checa("carrega", 32'(db_estado), 2);
      checa("carrega_sinais", 32'({rst_global, e_seed_reg}), 2'b01);
      ciclo();
      checa("espera0", 32'(db_estado), 6);
      checa("espera0_sinais", 32'({rst_global, e_seed_reg}), 0);
      ciclo();
   endtask

   initial begin
      int m0;
      rst_global_n = 1'b0; iniciar = 1'b0; confirma = 1'b0; CJ_fim = 1'b0;
      jogador_vivo = 1'b1; votou = 1'b0; acertou = 1'b0; sinal_lobo_ganhou = 1'b0;
      ciclo(); ciclo();
      checa("rst_estado", 32'(db_estado), 0);
      checa("rst_zera_CS", 32'(zera_CS), 1);
      checa("rst_saidas", 32'({rst_global, zera_CJ, inc_seed, e_seed_reg, inc_jogador,
            mostra_classe, processar_acao, avaliar_eliminacao, voto, morra,
            lobo_venceu, aldeia_venceu}), 12'b0010_0000_0000);
      rst_global_n = 1'b1;
      confirma = 1'b1;
      ciclo();
      confirma = 1'b0;
      checa("inicial_ignora_confirma", 32'(db_estado), 0);
      checa("zera_CS_solto", 32'(zera_CS), 0);

      // Game 1: full night, rejected vote, wrong vote, then village wins
      inicia_jogo();
      noite(5'b11111);
      checa("avaliar_pulsos", 32'(n_aval), 1);
      ciclo();
      checa("dia_voto_espera", 32'(db_estado), 9);
      iniciar = 1'b1;
      confirma = 1'b1;
      ciclo();
      iniciar = 1'b0;
      confirma = 1'b0;
      checa("dia_vota", 32'(db_estado), 10);
      checa("voto", 32'(voto), 1);
      m0 = n_morra;
      votou = 1'b0;
      ciclo();
      checa("dia_checa", 32'(db_estado), 11);
      ciclo();
      checa("voto_rejeitado", 32'(db_estado), 9);
      checa("rejeitado_sem_morra", 32'(n_morra - m0), 0);
      confirma = 1'b1; ciclo(); confirma = 1'b0;
      votou = 1'b1; acertou = 1'b0;
      ciclo();
      ciclo();
      checa("dia_elimina", 32'(db_estado), 12);
      checa("morra", 32'(morra), 1);
      ciclo();
      checa("verifica_dia", 32'(db_estado), 13);
      checa("verifica_dia_zera_CJ", 32'(zera_CJ), 1);
      ciclo();
      checa("volta_noite", 32'(db_estado), 6);
      ciclo();

      // Night 2: player 2 dead
      noite(5'b11011);
      confirma = 1'b1; ciclo(); confirma = 1'b0;
      votou = 1'b1; acertou = 1'b1;
      ciclo(); ciclo();
      checa("fim_aldeia", 32'(db_estado), 15);
      checa("aldeia_flags", 32'({aldeia_venceu, lobo_venceu, inc_seed}), 3'b101);
      confirma = 1'b1; ciclo(); confirma = 1'b0;
      checa("fim_ignora_confirma", 32'(db_estado), 15);

      // Game 2: all dead at night, wolf wins after elimination
      inicia_jogo();
      noite(5'b00000);
      confirma = 1'b1; ciclo(); confirma = 1'b0;
      votou = 1'b1; acertou = 1'b0; sinal_lobo_ganhou = 1'b1;
      ciclo(); ciclo();
      checa("elimina2", 32'(morra), 1);
      ciclo();
      checa("verifica_dia2", 32'(morra), 0);
      ciclo();
      checa("fim_lobo", 32'(db_estado), 14);
      checa("lobo_flags", 32'({lobo_venceu, aldeia_venceu, inc_seed}), 3'b101);
      sinal_lobo_ganhou = 1'b0;

      // Game 3: reset in the middle of the vote
      inicia_jogo();
      noite(5'b00000);
      confirma = 1'b1; ciclo(); confirma = 1'b0;
      checa("pre_reset_vota", 32'(db_estado), 10);
      rst_global_n = 1'b0;
      ciclo();
      rst_global_n = 1'b1;
      checa("reset_meio_voto", 32'(db_estado), 0);
      checa("reset_voto", 32'(voto), 0);

      // Game 4: idle vote
      inicia_jogo();
      noite(5'b00000);
      m0 = n_morra;
`ifdef CONTROLE_TIMEOUT_EN
      repeat (7) ciclo();
      checa("timeout_ainda_voto", 32'(db_estado), 9);
      ciclo();
      checa("timeout_verifica_dia", 32'(db_estado), 13);
      checa("timeout_sem_morra", 32'(n_morra - m0), 0);
`else
      repeat (20) ciclo();
      checa("sem_timeout_voto", 32'(db_estado), 9);
`endif

      checa("exclusividade", 32'(n_multi), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_falhas);
      $finish;
   end

endmodule
